apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester that drives the same APB bus our slaves respond to.
- Converts a single-beat command interface (valid/ready) into APB SETUP/ACCESS phases.
- Returns read data and error status on a one-cycle response strobe.
- Sits between the AHB-side bridge logic and one APB slave: single select, no address decode.

Parameters:
- ADDR_W, 32, width of PADDR and cmd_addr.
- DATA_W, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT, 16, number of ACCESS cycles with PREADY low before abort (used only with the optional feature; minimum 1).

Ports:
- PCLK in 1: bus clock.
- PRESET in 1: reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: command accepted when high together with cmd_valid.
- cmd_addr in ADDR_W: transfer address.
- cmd_write in 1: 1 = write, 0 = read.
- cmd_wdata in DATA_W: write data.
- rsp_valid out 1: one-cycle completion strobe.
- rsp_rdata out DATA_W: read data; 0 for writes.
- rsp_slverr out 1: slave or timeout error.
- PSELx out 1: slave select.
- PENABLE out 1: ACCESS phase indicator.
- PADDR out ADDR_W: APB address.
- PWRITE out 1: APB direction.
- PWDATA out DATA_W: APB write data.
- PRDATA in DATA_W: slave read data.
- PREADY in 1: slave ready.
- PSLVERR in 1: slave error.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. The clock is PCLK and the reset is PRESET.
- Reset values: all outputs are 0, including PSELx, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata and rsp_slverr. cmd_ready is forced to 0 while PRESET is high.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register cmd_addr, cmd_write and cmd_wdata into PADDR, PWRITE and PWDATA, set PSELx=1, and go to SETUP.
  - On a read, PWDATA holds its previous value.
- SETUP: PSELx=1, PENABLE=0. Unconditionally go to ACCESS next edge with PENABLE=1.
- ACCESS, PREADY=0: hold all APB outputs (wait state).
- ACCESS, PREADY=1: transfer completes at this edge.
  - Next cycle: rsp_valid=1, rsp_slverr=PSLVERR, rsp_rdata = PRDATA for a read, 0 for a write. PRDATA and PSLVERR are sampled only at this edge.
  - PENABLE drops to 0.
  - If cmd_valid is also high, the next command is accepted (cmd_ready=1 in this cycle). PSELx stays 1 with the new PADDR/PWRITE/PWDATA, and the state goes to SETUP (back-to-back).
  - Otherwise PSELx drops to 0 and the state returns to IDLE.
- cmd_ready: combinational, high when state==IDLE, or when state==ACCESS && PREADY. Low in all other cycles.
- Latency:
  - Zero-wait transfer: accept edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid in cycle N+3.
  - Each PREADY-low ACCESS cycle adds 1.
- Response handshake: rsp_valid is a single-cycle pulse with no backpressure. The consumer must sample it.
- Signal stability: PADDR, PWRITE and PWDATA are stable from SETUP through the completing ACCESS cycle.
- PREADY and PSLVERR are ignored outside ACCESS.
- Reset mid-transfer: the transfer is abandoned. PSELx and PENABLE are 0 after the reset edge, no rsp_valid is issued, and the state returns to IDLE.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT, the transfer completes as if PREADY=1, with rsp_slverr=1 and rsp_rdata=0. PSELx drops and the state returns to IDLE.
  - No back-to-back acceptance occurs on a timeout edge (cmd_ready=0 in that cycle).
  - If PREADY=1 arrives on the same edge as the counter reaching TIMEOUT, the slave response wins.
- Without the macro: ACCESS waits indefinitely and TIMEOUT is unused.

Decomposition:
- Shared package apb_pkg:
  - State encoding: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - Default ADDR_W/DATA_W constants.
  - Response struct {rdata, slverr} for the bridge side.
- Natural sub-module: apb_wait_timer, containing the TIMEOUT counter with clear/increment/expired. It is instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write, zero wait: cmd addr=0x10, wdata=0xDEADBEEF, write=1; PREADY tied 1.
  - Expect PSELx high cycles N+1..N+2, PENABLE high only in N+2, PWDATA=0xDEADBEEF, PWRITE=1.
  - Expect rsp_valid in N+3 with rsp_rdata=0 and rsp_slverr=0.
- Read, 2 wait states: addr=0x20; PREADY low for 2 ACCESS cycles, then high with PRDATA=0x12345678.
  - Expect rsp_valid in N+5 with rsp_rdata=0x12345678 and outputs stable throughout.
- Slave error: read addr=0x04, PSLVERR=1 with PREADY.
  - Expect rsp_slverr=1 and rsp_rdata equal to PRDATA.
- Back-to-back: cmd_valid held high for writes to 0x0 then 0x4.
  - Expect PSELx never drops between them, PENABLE 1-0-1, second SETUP immediately after first ACCESS, and two rsp_valid pulses 2 cycles apart.
- Timeout (macro on, TIMEOUT=4): PREADY held 0.
  - Expect abort after 4 ACCESS cycles with rsp_slverr=1, rsp_rdata=0, PSELx=0 the next cycle.
- Reset mid-ACCESS: assert PRESET during a wait state.
  - Expect PSELx=0, PENABLE=0 and all outputs 0 next cycle, no rsp_valid, and a new command accepted after reset is released.

Source files
------------

// File: rtl/apb_master_pkg.sv
// apb_pkg: shared state encoding, default bus widths and bridge-side response type for apb_master.
package apb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10} apb_state_t;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
  } apb_rsp_t;
endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command, response and APB bus signals of apb_master; master = requester view, slave = environment view.
import apb_pkg::*;
interface apb_master_if #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              PSELx;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts PREADY-low ACCESS cycles; o_expired flags the cycle whose edge reaches TIMEOUT.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || i_clr) ? '0 : i_inc ? r_cnt + 1'b1 : r_cnt;
  assign o_expired = i_inc && (r_cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/apb_master.sv
// apb_master: single-beat valid/ready command to APB SETUP/ACCESS requester; APB_MASTER_TIMEOUT_EN adds a wait-state abort.
import apb_pkg::*;
module apb_master #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
`ifdef APB_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic PCLK,
  input  logic PRESET,
  apb_master_if.master bus
);
  apb_state_t        r_state;
  logic              r_psel, r_penable, r_pwrite, r_rsp_valid, r_rsp_slverr;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata, r_rsp_rdata;
  logic              w_done, w_expired, w_load;
  assign w_done = (r_state == ACCESS) && bus.PREADY;
  assign bus.cmd_ready = !PRESET && ((r_state == IDLE) || w_done);
  assign w_load = bus.cmd_ready && bus.cmd_valid;
`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (PCLK),
    .rst      (PRESET),
    .i_clr    (r_state == SETUP),
    .i_inc    ((r_state == ACCESS) && !bus.PREADY),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state      <= IDLE;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else begin
      r_rsp_valid <= w_done || w_expired;
      if (w_done || w_expired) begin
        r_rsp_slverr <= w_expired || bus.PSLVERR;
        r_rsp_rdata  <= (w_expired || r_pwrite) ? '0 : bus.PRDATA;
      end
      // reads leave PWDATA untouched so the bus does not toggle needlessly
      if (w_load) begin
        r_paddr  <= bus.cmd_addr;
        r_pwrite <= bus.cmd_write;
        if (bus.cmd_write) r_pwdata <= bus.cmd_wdata;
      end
      case (r_state)
        IDLE: if (w_load) begin
          r_psel  <= 1'b1;
          r_state <= SETUP;
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: if (w_done || w_expired) begin
          r_penable <= 1'b0;
          r_psel    <= w_load;
          r_state   <= w_load ? SETUP : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.PSELx      = r_psel;
  assign bus.PENABLE    = r_penable;
  assign bus.PADDR      = r_paddr;
  assign bus.PWRITE     = r_pwrite;
  assign bus.PWDATA     = r_pwdata;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_slverr = r_rsp_slverr;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard bench for apb_master; define APB_MASTER_TIMEOUT_EN to exercise the timeout build with TIMEOUT=4.
import apb_pkg::*;
module tb_apb_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_master #(
    .ADDR_W(32), .DATA_W(32)
`ifdef APB_MASTER_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus)
  );
  apb_rsp_t sb[$];
  int vec = 0;
  int err = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic [31:0] a, input logic w, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_write = w;
    bus.cmd_wdata = d;
  endtask
  task automatic test_reset();
    logic [101:0] o;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0; bus.cmd_wdata = '0;
    bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    repeat (3) tick();
    o = {bus.PSELx, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr, bus.cmd_ready};
    vec++;
    if (o !== '0) begin err++; $display("FAIL reset_outputs got %h required 0", o); end
    rst = 1'b0;
    #1;
    vec++;
    if (bus.cmd_ready !== 1'b1) begin err++; $display("FAIL reset_release_ready got %b required 1", bus.cmd_ready); end
  endtask
  task automatic test_write_zero_wait();
    logic [4:0] ps = 5'b00110, pe = 5'b00100, rv = 5'b01000;
    apb_rsp_t e;
    cmd(32'h10, 1'b1, 32'hDEADBEEF);
    bus.PREADY = 1'b1; bus.PRDATA = 32'hA5A5A5A5; bus.PSLVERR = 1'b0;
    #1;
    vec++;
    if (bus.cmd_ready !== 1'b1) begin err++; $display("FAIL wr_accept ready got %b required 1", bus.cmd_ready); end
    sb.push_back(apb_rsp_t'{rdata: 32'h0, slverr: 1'b0});
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      vec++;
      if ({bus.PSELx, bus.PENABLE, bus.rsp_valid} !== {ps[k], pe[k], rv[k]}) begin
        err++; $display("FAIL wr_trace k=%0d got sel/en/rv=%b%b%b required %b%b%b", k, bus.PSELx, bus.PENABLE, bus.rsp_valid, ps[k], pe[k], rv[k]);
      end
      if (ps[k] && {bus.PADDR, bus.PWRITE, bus.PWDATA} !== {32'h10, 1'b1, 32'hDEADBEEF}) begin
        err++; $display("FAIL wr_bus k=%0d got %h/%b/%h required 10/1/deadbeef", k, bus.PADDR, bus.PWRITE, bus.PWDATA);
      end
      if (bus.rsp_valid) begin
        if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
        vec++;
        if ({bus.rsp_rdata, bus.rsp_slverr} !== e) begin
          err++; $display("FAIL wr_rsp got %h/%b required %h/%b", bus.rsp_rdata, bus.rsp_slverr, e.rdata, e.slverr);
        end
      end
    end
  endtask
  task automatic test_read_wait();
    logic [6:0] ps = 7'b0011110, pe = 7'b0011100, rv = 7'b0100000, cr = 7'b1110000;
    apb_rsp_t e;
    cmd(32'h20, 1'b0, 32'h0BADF00D);
    bus.PREADY = 1'b0; bus.PRDATA = 32'hFFFF0000;
    sb.push_back(apb_rsp_t'{rdata: 32'h12345678, slverr: 1'b0});
    for (int k = 1; k <= 6; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      bus.PREADY = (k == 4);
      bus.PRDATA = (k == 4) ? 32'h12345678 : 32'hFFFF0000;
      #1;
      vec++;
      if ({bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.cmd_ready} !== {ps[k], pe[k], rv[k], cr[k]}) begin
        err++; $display("FAIL rd_trace k=%0d got sel/en/rv/rdy=%b%b%b%b required %b%b%b%b", k, bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.cmd_ready, ps[k], pe[k], rv[k], cr[k]);
      end
      if (ps[k] && {bus.PADDR, bus.PWRITE, bus.PWDATA} !== {32'h20, 1'b0, 32'hDEADBEEF}) begin
        err++; $display("FAIL rd_bus k=%0d got %h/%b/%h required 20/0/deadbeef", k, bus.PADDR, bus.PWRITE, bus.PWDATA);
      end
      if (bus.rsp_valid) begin
        if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
        vec++;
        if ({bus.rsp_rdata, bus.rsp_slverr} !== e) begin
          err++; $display("FAIL rd_rsp got %h/%b required %h/%b", bus.rsp_rdata, bus.rsp_slverr, e.rdata, e.slverr);
        end
      end
    end
  endtask
  task automatic test_slave_error();
    logic [4:0] ps = 5'b00110, pe = 5'b00100, rv = 5'b01000;
    apb_rsp_t e;
    cmd(32'h04, 1'b0, 32'h0);
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 32'hCAFEF00D;
    sb.push_back(apb_rsp_t'{rdata: 32'hCAFEF00D, slverr: 1'b1});
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      vec++;
      if ({bus.PSELx, bus.PENABLE, bus.rsp_valid} !== {ps[k], pe[k], rv[k]}) begin
        err++; $display("FAIL err_trace k=%0d got sel/en/rv=%b%b%b required %b%b%b", k, bus.PSELx, bus.PENABLE, bus.rsp_valid, ps[k], pe[k], rv[k]);
      end
      if (bus.rsp_valid) begin
        if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
        vec++;
        if ({bus.rsp_rdata, bus.rsp_slverr} !== e) begin
          err++; $display("FAIL err_rsp got %h/%b required %h/%b", bus.rsp_rdata, bus.rsp_slverr, e.rdata, e.slverr);
        end
      end
    end
    bus.PSLVERR = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic [5:0] ps = 6'b011110, pe = 6'b010100, rv = 6'b101000, cr = 6'b110100;
    apb_rsp_t e;
    cmd(32'h0, 1'b1, 32'h11111111);
    bus.PREADY = 1'b1; bus.PRDATA = 32'h99999999;
    sb.push_back(apb_rsp_t'{rdata: 32'h0, slverr: 1'b0});
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin cmd(32'h4, 1'b1, 32'h22222222); sb.push_back(apb_rsp_t'{rdata: 32'h0, slverr: 1'b0}); end
      if (k == 3) bus.cmd_valid = 1'b0;
      #1;
      vec++;
      if ({bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.cmd_ready} !== {ps[k], pe[k], rv[k], cr[k]}) begin
        err++; $display("FAIL b2b_trace k=%0d got sel/en/rv/rdy=%b%b%b%b required %b%b%b%b", k, bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.cmd_ready, ps[k], pe[k], rv[k], cr[k]);
      end
      if (ps[k] && {bus.PADDR, bus.PWDATA} !== ((k <= 2) ? {32'h0, 32'h11111111} : {32'h4, 32'h22222222})) begin
        err++; $display("FAIL b2b_bus k=%0d got %h/%h", k, bus.PADDR, bus.PWDATA);
      end
      if (bus.rsp_valid) begin
        if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
        vec++;
        if ({bus.rsp_rdata, bus.rsp_slverr} !== e) begin
          err++; $display("FAIL b2b_rsp got %h/%b required %h/%b", bus.rsp_rdata, bus.rsp_slverr, e.rdata, e.slverr);
        end
      end
    end
  endtask
`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] ps = 8'b00111110, pe = 8'b00111100, rv = 8'b01000000, cr = 8'b11000000;
    apb_rsp_t e;
    cmd(32'h30, 1'b0, 32'h0);
    bus.PREADY = 1'b0; bus.PRDATA = 32'h77777777;
    sb.push_back(apb_rsp_t'{rdata: 32'h0, slverr: 1'b1});
    for (int k = 1; k <= 7; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      if (k == 5) cmd(32'h34, 1'b1, 32'h5A5A5A5A);
      #1;
      vec++;
      if ({bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.cmd_ready} !== {ps[k], pe[k], rv[k], cr[k]}) begin
        err++; $display("FAIL to_trace k=%0d got sel/en/rv/rdy=%b%b%b%b required %b%b%b%b", k, bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.cmd_ready, ps[k], pe[k], rv[k], cr[k]);
      end
      if (bus.rsp_valid) begin
        if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
        vec++;
        if ({bus.rsp_rdata, bus.rsp_slverr} !== e) begin
          err++; $display("FAIL to_rsp got %h/%b required %h/%b", bus.rsp_rdata, bus.rsp_slverr, e.rdata, e.slverr);
        end
      end
    end
  endtask
`else
  task automatic test_long_wait();
    apb_rsp_t e;
    cmd(32'h30, 1'b0, 32'h0);
    bus.PREADY = 1'b0; bus.PRDATA = 32'h0;
    sb.push_back(apb_rsp_t'{rdata: 32'h31415926, slverr: 1'b0});
    for (int k = 1; k <= 23; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      bus.PREADY = (k == 21);
      bus.PRDATA = (k == 21) ? 32'h31415926 : 32'h0;
      vec++;
      if ({bus.PSELx, bus.PENABLE, bus.rsp_valid} !== {k <= 21, k >= 2 && k <= 21, k == 22}) begin
        err++; $display("FAIL long_trace k=%0d got sel/en/rv=%b%b%b", k, bus.PSELx, bus.PENABLE, bus.rsp_valid);
      end
      if (bus.rsp_valid) begin
        if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
        vec++;
        if ({bus.rsp_rdata, bus.rsp_slverr} !== e) begin
          err++; $display("FAIL long_rsp got %h/%b required %h/%b", bus.rsp_rdata, bus.rsp_slverr, e.rdata, e.slverr);
        end
      end
    end
  endtask
`endif
  task automatic test_reset_mid();
    logic [101:0] o;
    logic [4:0] ps = 5'b00110, pe = 5'b00100, rv = 5'b01000;
    apb_rsp_t e;
    cmd(32'h40, 1'b0, 32'h0);
    bus.PREADY = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      vec++;
      if ({bus.PSELx, bus.PENABLE, bus.rsp_valid} !== {1'b1, k >= 2, 1'b0}) begin
        err++; $display("FAIL rstmid_pre k=%0d got sel/en/rv=%b%b%b", k, bus.PSELx, bus.PENABLE, bus.rsp_valid);
      end
    end
    rst = 1'b1;
    tick();
    o = {bus.PSELx, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr, bus.cmd_ready};
    vec++;
    if (o !== '0) begin err++; $display("FAIL rstmid_outputs got %h required 0", o); end
    rst = 1'b0;
    bus.PREADY = 1'b1;
    tick();
    vec++;
    if ({bus.PSELx, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
      err++; $display("FAIL rstmid_idle got sel/rv/rdy=%b%b%b required 001", bus.PSELx, bus.rsp_valid, bus.cmd_ready);
    end
    cmd(32'h44, 1'b1, 32'h00000055);
    sb.push_back(apb_rsp_t'{rdata: 32'h0, slverr: 1'b0});
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      vec++;
      if ({bus.PSELx, bus.PENABLE, bus.rsp_valid} !== {ps[k], pe[k], rv[k]}) begin
        err++; $display("FAIL rstmid_new k=%0d got sel/en/rv=%b%b%b required %b%b%b", k, bus.PSELx, bus.PENABLE, bus.rsp_valid, ps[k], pe[k], rv[k]);
      end
      if (ps[k] && {bus.PADDR, bus.PWDATA} !== {32'h44, 32'h55}) begin
        err++; $display("FAIL rstmid_bus k=%0d got %h/%h required 44/55", k, bus.PADDR, bus.PWDATA);
      end
      if (bus.rsp_valid) begin
        if (sb.size() != 0) e = sb.pop_front(); else e = 'x;
        vec++;
        if ({bus.rsp_rdata, bus.rsp_slverr} !== e) begin
          err++; $display("FAIL rstmid_rsp got %h/%b required %h/%b", bus.rsp_rdata, bus.rsp_slverr, e.rdata, e.slverr);
        end
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid();
    vec++;
    if (sb.size() != 0) begin err++; $display("FAIL scoreboard_drain got %0d pending required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
